// File: rtl/source_arbiter.sv
// source_arbiter: round-robin funnel from N two-phase (toggle) req/ack sources
// onto one downstream toggle channel. One flit is in flight at a time; the
// source is acknowledged only after the sink has acknowledged the flit.

`ifndef SIZE
`define SIZE 8
`endif

module source_arbiter #(
  parameter int N       = 4,
  parameter int GW      = 2,
  parameter int ID      = 0,
  parameter int VERBOSE = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         in_req,
  output logic [N-1:0]         in_ack,
  input  logic [N*`SIZE-1:0]   in_data,
  output logic                 out_req,
  input  logic                 out_ack,
  output logic [`SIZE-1:0]     out_data,
  output logic [GW-1:0]        grant,
  output logic                 busy,
  output logic [15:0]          xfer_cnt
);

  // Reject unusable parameter sets at elaboration time.
  if (N < 2 || N > 16 || (1 << GW) < N || ID < 0 || VERBOSE < 0 || VERBOSE > 1) begin : g_bad_params
    $error("source_arbiter: illegal parameter combination");
  end

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_t;

  state_t         state, state_next;
  logic [N-1:0]   pending;
  logic [GW-1:0]  win;
  logic           any_pending;
  logic           done;
  logic           launch;
  logic           finish;

  // A source is pending while its req and ack levels differ; the downstream
  // flit is complete once the sink's ack level has caught up with our req.
  assign pending     = in_req ^ in_ack;
  assign any_pending = |pending;
  assign done        = (out_req == out_ack);

  // Round-robin pick: scan grant+1, grant+2, ... modulo N; first pending wins.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    win = grant;
    for (int k = N; k >= 1; k--) begin
      if (pending[(int'(grant) + k) % N]) begin
        win = GW'((int'(grant) + k) % N);
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples pre-edge values regardless of block ordering.
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and the launch/finish strobes that drive the datapath.
  always_comb begin
    state_next = state;
    launch     = 1'b0;
    finish     = 1'b0;
    case (state)
      S_IDLE: begin
        if (any_pending) begin
          launch     = 1'b1;
          state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (done) begin
          finish     = 1'b1;
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Registered outputs: forward the winning flit on launch, acknowledge the
  // granted source and count the transfer on finish.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_ack   <= '0;
      out_req  <= 1'b0;
      out_data <= '0;
      grant    <= GW'(N - 1);
      busy     <= 1'b0;
      xfer_cnt <= 16'd0;
    end else begin
      if (launch) begin
        out_data <= in_data[int'(win) * `SIZE +: `SIZE];
        out_req  <= ~out_req;
        grant    <= win;
        busy     <= 1'b1;
      end
      if (finish) begin
        in_ack[grant] <= ~in_ack[grant];
        busy          <= 1'b0;
        if (xfer_cnt != 16'hFFFF) begin
          xfer_cnt <= xfer_cnt + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_source_arbiter.sv
// Self-checking bench for source_arbiter: directed scenarios plus randomized
// traffic, all compared cycle by cycle against a transaction-level model.

`ifndef SIZE
`define SIZE 8
`endif

module tb_source_arbiter;

  localparam int N  = 4;
  localparam int GW = 2;
  localparam int SZ = `SIZE;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [N-1:0]      in_req = '0;
  logic [N-1:0]      in_ack;
  logic [N*SZ-1:0]   in_data = '0;
  logic              out_req;
  logic              out_ack = 1'b0;
  logic [SZ-1:0]     out_data;
  logic [GW-1:0]     grant;
  logic              busy;
  logic [15:0]       xfer_cnt;

  int n_vec = 0;
  int n_bad = 0;

  source_arbiter #(.N(N), .GW(GW), .ID(0), .VERBOSE(0)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_req   (in_req),
    .in_ack   (in_ack),
    .in_data  (in_data),
    .out_req  (out_req),
    .out_ack  (out_ack),
    .out_data (out_data),
    .grant    (grant),
    .busy     (busy),
    .xfer_cnt (xfer_cnt)
  );

  always #5 clk = ~clk;

  // Reference model state: one outstanding flit, last-served port, per-port ack levels.
  bit [N-1:0]  m_ack;
  bit          m_req;
  bit [SZ-1:0] m_data;
  int          m_grant;
  bit          m_busy;
  int          m_cnt;

  // Sink behaviour.
  bit sink_en    = 1'b0;
  bit sink_rand  = 1'b0;
  int sink_delay = 0;
  int sink_wait  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ack   = '0;
    m_req   = 1'b0;
    m_data  = '0;
    m_grant = N - 1;
    m_busy  = 1'b0;
    m_cnt   = 0;
  endtask

  // One clock edge of the reference: either start the next flit in
  // round-robin order after the last served port, or retire the outstanding one.
  task automatic model_edge();
    if (!m_busy) begin
      for (int k = 1; k <= N; k++) begin
        int p;
        p = (m_grant + k) % N;
        if (in_req[p] != m_ack[p]) begin
          m_data  = in_data[p*SZ +: SZ];
          m_req   = !m_req;
          m_grant = p;
          m_busy  = 1'b1;
          break;
        end
      end
    end else if (out_ack == m_req) begin
      m_ack[m_grant] = !m_ack[m_grant];
      m_busy         = 1'b0;
      m_cnt          = (m_cnt >= 65535) ? 65535 : m_cnt + 1;
    end
  endtask

  function automatic bit src_pending(input int p);
    return in_req[p] != m_ack[p];
  endfunction

  task automatic send(input int p, input logic [SZ-1:0] d);
    in_data[p*SZ +: SZ] = d;
    in_req[p]           = ~in_req[p];
  endtask

  task automatic sink_drive();
    if (sink_en && out_req != out_ack) begin
      if (sink_wait >= sink_delay) begin
        out_ack   = out_req;
        sink_wait = 0;
        if (sink_rand) sink_delay = $urandom_range(0, 4);
      end else begin
        sink_wait++;
      end
    end
  endtask

  // Called at a negedge with stimulus applied; advances one clock and compares.
  task automatic step();
    sink_drive();
    model_edge();
    @(posedge clk);
    #1;
    check("in_ack",   32'(in_ack),   32'(m_ack));
    check("out_req",  32'(out_req),  32'(m_req));
    check("out_data", 32'(out_data), 32'(m_data));
    check("grant",    32'(grant),    32'(m_grant));
    check("busy",     32'(busy),     32'(m_busy));
    check("xfer_cnt", 32'(xfer_cnt), 32'(m_cnt));
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset     = 1'b0;
    in_req    = '0;
    in_data   = '0;
    out_ack   = 1'b0;
    sink_wait = 0;
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    int   grants[$];
    bit   prev_busy;
    bit   p3_sent;
    bit   look;
    int   next_g;

    // 1: reset state, then 20 idle cycles
    do_reset();
    check("rst_out_req",  32'(out_req),  0);
    check("rst_busy",     32'(busy),     0);
    check("rst_in_ack",   32'(in_ack),   0);
    check("rst_xfer_cnt", 32'(xfer_cnt), 0);
    check("rst_grant",    32'(grant),    N - 1);
    check("rst_out_data", 32'(out_data), 0);
    repeat (20) step();

    // 2: single flit from port 2, sink acks three cycles after out_req toggles
    sink_en = 1'b0;
    send(2, 8'd4);
    step();
    check("t2_out_req",  32'(out_req),  1);
    check("t2_out_data", 32'(out_data), 4);
    check("t2_grant",    32'(grant),    2);
    check("t2_busy",     32'(busy),     1);
    step();
    step();
    check("t2_no_early_ack", 32'(in_ack), 0);
    out_ack = 1'b1;
    step();
    check("t2_in_ack",   32'(in_ack),   32'h4);
    check("t2_xfer_cnt", 32'(xfer_cnt), 1);
    step();

    // 3: all ports request together, sink acks after one cycle
    do_reset();
    sink_en = 1'b1; sink_rand = 1'b0; sink_delay = 1;
    for (int p = 0; p < N; p++) send(p, 8'(8'h10 + p));
    prev_busy = 1'b0;
    grants.delete();
    repeat (20) begin
      step();
      if (busy && !prev_busy) grants.push_back(int'(grant));
      prev_busy = busy;
    end
    check("t3_n_grants", 32'(grants.size()), 4);
    for (int i = 0; i < 4 && i < grants.size(); i++) check("t3_order", 32'(grants[i]), 32'(i));
    check("t3_in_ack",   32'(in_ack),   32'hF);
    check("t3_xfer_cnt", 32'(xfer_cnt), 4);

    // 4: port 1 streams, port 3 requests once while a port-1 flit is in flight
    do_reset();
    sink_en = 1'b1; sink_rand = 1'b0; sink_delay = 1;
    p3_sent = 1'b0; look = 1'b0; next_g = 99; prev_busy = 1'b0;
    repeat (40) begin
      if (!src_pending(1)) send(1, 8'($urandom));
      if (!p3_sent && m_busy && m_grant == 1) begin
        send(3, 8'hC3);
        p3_sent = 1'b1;
        look    = 1'b1;
        step();
        prev_busy = busy;
        continue;
      end
      step();
      if (look && busy && !prev_busy) begin
        next_g = int'(grant);
        look   = 1'b0;
      end
      prev_busy = busy;
    end
    check("t4_next_grant", 32'(next_g),    3);
    check("t4_p3_acked",   32'(in_ack[3]), 1);

    // 5: asynchronous reset while waiting with out_req high
    do_reset();
    sink_en = 1'b0;
    send(1, 8'h5A);
    step();
    step();
    check("t5_pre_out_req", 32'(out_req), 1);
    #2;
    reset = 1'b0;
    #1;
    check("t5_in_ack",   32'(in_ack),   0);
    check("t5_out_req",  32'(out_req),  0);
    check("t5_out_data", 32'(out_data), 0);
    check("t5_grant",    32'(grant),    N - 1);
    check("t5_busy",     32'(busy),     0);
    check("t5_xfer_cnt", 32'(xfer_cnt), 0);
    in_req  = '0;
    out_ack = 1'b0;
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    send(3, 8'h77);
    step();
    check("t5_regrant",   32'(grant),    3);
    check("t5_reg_data",  32'(out_data), 32'h77);

    // Randomized traffic with random sink latency, then drain
    sink_en = 1'b1; sink_rand = 1'b1; sink_delay = 2;
    repeat (400) begin
      for (int p = 0; p < N; p++)
        if (!src_pending(p) && $urandom_range(0, 3) == 0) send(p, 8'($urandom));
      step();
    end
    repeat (30) step();
    check("drain_busy", 32'(busy), 0);

    // 6: counter saturation from a preloaded value near the top
    sink_rand = 1'b0; sink_delay = 0;
    force dut.xfer_cnt = 16'hFFFD;
    #1;
    release dut.xfer_cnt;
    m_cnt = 65533;
    repeat (24) begin
      for (int p = 0; p < N; p++)
        if (!src_pending(p)) send(p, 8'($urandom));
      step();
    end
    check("t6_saturated", 32'(xfer_cnt), 32'hFFFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
